// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_ctrl
// Brief    : Time-multiplexed scan controller for a common-anode multi-digit
//            seven-segment display with guard gaps and leading-zero blanking.
// Revision : 1.0
// ============================================================================
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    lz_blank,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    output logic [3:0]              digit_nibble,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    dp_n,
    output logic                    frame_tick
);

    localparam int c_MAX_CYC = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
    localparam int c_IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [c_CNT_W-1:0] c_GUARD_LAST = c_CNT_W'(GUARD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GUARD = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_IDX_W-1:0]        r_idx;
    logic [c_IDX_W-1:0]        w_idx_nxt;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [c_CNT_W-1:0]        w_cnt_nxt;
    logic                      w_frame_start;

    logic [4*NUM_DIGITS-1:0]   r_disp;
    logic [NUM_DIGITS-1:0]     r_disp_dp;
    logic [4*NUM_DIGITS-1:0]   r_pend;
    logic [NUM_DIGITS-1:0]     r_pend_dp;
    logic                      r_pend_valid;
    logic                      w_xfer;
    logic [4*NUM_DIGITS-1:0]   w_disp_nxt;
    logic [NUM_DIGITS-1:0]     w_disp_dp_nxt;

    logic [NUM_DIGITS-1:0]     w_blank;
    logic [3:0]                w_nib_sel;
    logic                      w_dp_sel;
    logic                      w_blank_sel;
    logic [NUM_DIGITS-1:0]     w_an_n;
    logic                      w_dp_n;
    logic [3:0]                w_nibble;

    logic [NUM_DIGITS-1:0]     r_an_n;
    logic                      r_dp_n;
    logic [3:0]                r_nibble;
    logic                      r_frame_tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt + c_CNT_W'(1);
        w_frame_start = 1'b0;
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt   = S_GUARD;
                    w_idx_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_frame_start = 1'b1;
                end
                S_GUARD: begin
                    if (r_cnt == c_GUARD_LAST) begin
                        w_state_nxt = S_DRIVE;
                        w_cnt_nxt   = '0;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == c_DWELL_LAST) begin
                        w_state_nxt = S_GUARD;
                        w_cnt_nxt   = '0;
                        if (r_idx == c_IDX_LAST) begin
                            w_idx_nxt     = '0;
                            w_frame_start = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + c_IDX_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Pending data lands on the display only at a frame boundary (or while idle),
    // so a frame is always drawn from one consistent value.
    assign w_xfer        = r_pend_valid & ((r_state == S_IDLE) | w_frame_start);
    assign w_disp_nxt    = w_xfer ? r_pend    : r_disp;
    assign w_disp_dp_nxt = w_xfer ? r_pend_dp : r_disp_dp;

    always_comb begin
        logic w_zero_run;
        w_zero_run = 1'b1;
        w_blank    = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_zero_run = w_zero_run & (w_disp_nxt[4*i +: 4] == 4'h0);
            w_blank[i] = lz_blank & w_zero_run;
        end
    end

    always_comb begin
        w_nib_sel   = 4'h0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_nxt == c_IDX_W'(i)) begin
                w_nib_sel   = w_disp_nxt[4*i +: 4];
                w_dp_sel    = w_disp_dp_nxt[i];
                w_blank_sel = w_blank[i];
            end
        end
    end

    // Outputs are computed for the upcoming state and registered, keeping them
    // aligned with the FSM while leaving no input-to-output combinational path.
    always_comb begin
        w_an_n   = '1;
        w_dp_n   = 1'b1;
        w_nibble = 4'h0;
        case (w_state_nxt)
            S_GUARD: w_nibble = w_nib_sel;
            S_DRIVE: begin
                w_nibble = w_nib_sel;
                if (!w_blank_sel) begin
                    w_an_n = ~(NUM_DIGITS'(1) << w_idx_nxt);
                    w_dp_n = ~w_dp_sel;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_disp       <= '0;
            r_disp_dp    <= '0;
            r_pend       <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_an_n       <= '1;
            r_dp_n       <= 1'b1;
            r_nibble     <= 4'h0;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_disp    <= r_pend;
                r_disp_dp <= r_pend_dp;
            end
            if (load_valid && !r_pend_valid) begin
                r_pend       <= load_data;
                r_pend_dp    <= load_dp;
                r_pend_valid <= 1'b1;
            end else if (w_xfer) begin
                r_pend_valid <= 1'b0;
            end
            r_an_n       <= w_an_n;
            r_dp_n       <= w_dp_n;
            r_nibble     <= w_nibble;
            r_frame_tick <= w_frame_start;
        end
    end

    assign load_ready   = ~r_pend_valid;
    assign an_n         = r_an_n;
    assign dp_n         = r_dp_n;
    assign digit_nibble = r_nibble;
    assign frame_tick   = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan_ctrl
// Brief    : Scoreboard bench for seven_seg_scan_ctrl (4 digits, dwell 4, guard 2).
// Revision : 1.0
// ============================================================================
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int DW    = 4;
    localparam int GC    = 2;
    localparam int FRAME = ND * (DW + GC);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        lz_blank = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic [3:0]  load_dp = 4'h0;
    logic        load_ready;
    logic [3:0]  digit_nibble;
    logic [3:0]  an_n;
    logic        dp_n;
    logic        frame_tick;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [9:0]  sb[$];
    logic [9:0]  exp_v;
    logic [9:0]  obs_v;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .DWELL_CYCLES(DW),
        .GUARD_CYCLES(GC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .lz_blank    (lz_blank),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_dp     (load_dp),
        .digit_nibble(digit_nibble),
        .an_n        (an_n),
        .dp_n        (dp_n),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    // Expected per-cycle {frame_tick, an_n, dp_n, digit_nibble} for one frame.
    task automatic push_frame(input logic [15:0] data, input logic [3:0] dp, input logic lz);
        logic [3:0] nib;
        logic [3:0] an;
        logic       blank;
        for (int d = 0; d < ND; d++) begin
            nib   = data[4*d +: 4];
            blank = lz && (d > 0) && ((data >> (4*d)) == 16'h0);
            an    = blank ? 4'hF : ~(4'b0001 << d);
            for (int c = 0; c < GC; c++) sb.push_back({(d == 0 && c == 0), 4'hF, 1'b1, nib});
            for (int c = 0; c < DW; c++) sb.push_back({1'b0, an, (blank ? 1'b1 : ~dp[d]), nib});
        end
    endtask

    // Called on a negedge with the DUT idle; enable rises as the value is captured.
    task automatic load_and_enable(input logic [15:0] data, input logic [3:0] dp);
        load_valid = 1'b1;
        load_data  = data;
        load_dp    = dp;
        @(negedge clk);
        load_valid = 1'b0;
        enable     = 1'b1;
    endtask

    task automatic go_idle();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b1; load_valid = 1'b1; load_data = 16'h5A5A; load_dp = 4'hF;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({an_n, dp_n, load_ready, digit_nibble, frame_tick} !== {4'hF, 1'b1, 1'b1, 4'h0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_state: an/dp/rdy/nib/tick=%b required %b",
                         {an_n, dp_n, load_ready, digit_nibble, frame_tick}, {4'hF, 1'b1, 1'b1, 4'h0, 1'b0});
            end
        end
        rst_n = 1'b1; load_valid = 1'b0;
        push_frame(16'h0000, 4'h0, 1'b0);
        for (int cyc = 0; cyc < FRAME; cyc++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = {frame_tick, an_n, dp_n, digit_nibble};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL reset_frame cyc=%0d: got %b required %b", cyc, obs_v, exp_v);
            end
        end
        go_idle();
    endtask

    task automatic test_scan();
        load_and_enable(16'h12AF, 4'b0100);
        n_checks++;
        if (load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_ready: got %b required 0", load_ready);
        end
        push_frame(16'h12AF, 4'b0100, 1'b0);
        push_frame(16'h12AF, 4'b0100, 1'b0);
        for (int cyc = 0; cyc < 2*FRAME; cyc++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = {frame_tick, an_n, dp_n, digit_nibble};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL scan cyc=%0d: got %b required %b", cyc, obs_v, exp_v);
            end
        end
        go_idle();
    endtask

    task automatic test_blanking();
        lz_blank = 1'b1;
        load_and_enable(16'h0070, 4'h0);
        push_frame(16'h0070, 4'h0, 1'b1);
        for (int cyc = 0; cyc < FRAME; cyc++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = {frame_tick, an_n, dp_n, digit_nibble};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL blank_0070 cyc=%0d: got %b required %b", cyc, obs_v, exp_v);
            end
        end
        go_idle();
        load_and_enable(16'h0000, 4'b1001);
        push_frame(16'h0000, 4'b1001, 1'b1);
        for (int cyc = 0; cyc < FRAME; cyc++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = {frame_tick, an_n, dp_n, digit_nibble};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL blank_0000 cyc=%0d: got %b required %b", cyc, obs_v, exp_v);
            end
        end
        lz_blank = 1'b0;
        go_idle();
    endtask

    task automatic test_midframe_load();
        logic exp_rdy;
        load_and_enable(16'h12AF, 4'h0);
        push_frame(16'h12AF, 4'h0, 1'b0);
        push_frame(16'hBEEF, 4'h0, 1'b0);
        push_frame(16'h1234, 4'h0, 1'b0);
        for (int cyc = 0; cyc < 3*FRAME; cyc++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = {frame_tick, an_n, dp_n, digit_nibble};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL midload cyc=%0d: got %b required %b", cyc, obs_v, exp_v);
            end
            if (cyc == 15 || cyc == 23 || cyc == 24 || cyc == 25 || cyc == 48) begin
                exp_rdy = (cyc == 24 || cyc == 48);
                n_checks++;
                if (load_ready !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL midload_ready cyc=%0d: got %b required %b", cyc, load_ready, exp_rdy);
                end
            end
            if (cyc == 14) begin
                load_valid = 1'b1; load_data = 16'hBEEF; load_dp = 4'h0;
            end else if (cyc == 15) begin
                load_data = 16'h1234;
            end else if (cyc == 25) begin
                load_valid = 1'b0;
            end
        end
        go_idle();
    endtask

    task automatic test_disable();
        load_and_enable(16'h12AF, 4'b0100);
        push_frame(16'h12AF, 4'b0100, 1'b0);
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = {frame_tick, an_n, dp_n, digit_nibble};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL disable_pre cyc=%0d: got %b required %b", cyc, obs_v, exp_v);
            end
        end
        sb.delete();
        enable = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({an_n, dp_n, frame_tick} !== {4'hF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL disable_dark: an/dp/tick=%b required %b", {an_n, dp_n, frame_tick}, {4'hF, 1'b1, 1'b0});
        end
        enable = 1'b1;
        push_frame(16'h12AF, 4'b0100, 1'b0);
        for (int cyc = 0; cyc < FRAME; cyc++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = {frame_tick, an_n, dp_n, digit_nibble};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL reenable cyc=%0d: got %b required %b", cyc, obs_v, exp_v);
            end
        end
        go_idle();
    endtask

    task automatic test_reset_pending();
        load_and_enable(16'h12AF, 4'h0);
        push_frame(16'h12AF, 4'h0, 1'b0);
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = {frame_tick, an_n, dp_n, digit_nibble};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL rstpend_pre cyc=%0d: got %b required %b", cyc, obs_v, exp_v);
            end
        end
        sb.delete();
        load_valid = 1'b1; load_data = 16'hBEEF;
        @(negedge clk);
        n_checks++;
        if (load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstpend_captured: load_ready=%b required 0", load_ready);
        end
        load_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({an_n, load_ready} !== {4'hF, 1'b1}) begin
            n_fail++;
            $display("FAIL rstpend_reset: an/rdy=%b required %b", {an_n, load_ready}, {4'hF, 1'b1});
        end
        rst_n = 1'b1;
        push_frame(16'h0000, 4'h0, 1'b0);
        for (int cyc = 0; cyc < FRAME; cyc++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = {frame_tick, an_n, dp_n, digit_nibble};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL rstpend_frame cyc=%0d: got %b required %b", cyc, obs_v, exp_v);
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blanking();
        test_midframe_load();
        test_disable();
        test_reset_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
